// File: rtl/serializer_pkg.sv
// Shared types and helpers for the word serializer: FSM state encoding and
// the ceiling-divide used to size the chunk count.
package serializer_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SEND,
    DONE
  } state_e;

  function automatic int ceil_div(input int a, input int b);
    return (a + b - 1) / b;
  endfunction

endpackage

// File: rtl/chunk_counter.sv
// Up-counter with enable and synchronous clear that wraps at LIMIT-1 and flags
// its terminal count.
module chunk_counter #(
  parameter int LIMIT = 9,
  parameter int CW    = $clog2(LIMIT + 1)
) (
  input  logic clk,
  input  logic reset,
  input  logic clear_i,
  input  logic enable_i,
  output logic terminal_o
);

  localparam logic [CW-1:0] LAST = CW'(LIMIT - 1);

  logic [CW-1:0] count_q, count_d;

  // Wrapping on the final chunk keeps the count inside 0..LIMIT-1 at all times.
  always_comb begin
    count_d = count_q;
    if (clear_i) begin
      count_d = '0;
    end else if (enable_i) begin
      count_d = (count_q == LAST) ? '0 : count_q + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign terminal_o = (count_q == LAST);

endmodule

// File: rtl/word_serializer_tx.sv
// Sends a wide result word out LSB-chunk first over a valid/ready handshake,
// then pulses Done for one cycle before returning to IDLE.
module word_serializer_tx
  import serializer_pkg::*;
#(
  parameter int Word_Lenght = 65,
  parameter int Chunk_Width = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   Start,
  input  logic                   Sync_Clear,
  input  logic [Word_Lenght-1:0] Data_Input,
  input  logic                   Chunk_Ready,
  output logic                   Chunk_Valid,
  output logic [Chunk_Width-1:0] Chunk_Output,
  output logic                   Last_Chunk,
  output logic                   Busy,
  output logic                   Done
);

  localparam int NUM_CHUNKS = ceil_div(Word_Lenght, Chunk_Width);
  localparam int SHREG_W    = NUM_CHUNKS * Chunk_Width;

  if (Chunk_Width > Word_Lenght || Chunk_Width < 1) begin : g_bad_width
    $error("word_serializer_tx: Chunk_Width must be in 1..Word_Lenght");
  end

  state_e               state_q, state_d;
  logic [SHREG_W-1:0]   shreg_q, shreg_d;
  logic                 capture;
  logic                 transfer;
  logic                 terminal;

  assign capture  = (state_q == IDLE) && Start && !Sync_Clear;
  assign transfer = (state_q == SEND) && Chunk_Ready;

  chunk_counter #(
    .LIMIT (NUM_CHUNKS)
  ) u_chunk_counter (
    .clk        (clk),
    .reset      (reset),
    .clear_i    (Sync_Clear || capture),
    .enable_i   (transfer && !Sync_Clear),
    .terminal_o (terminal)
  );

  // Sync_Clear overrides everything except reset, including an in-flight transfer.
  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    if (Sync_Clear) begin
      state_d = IDLE;
      shreg_d = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (Start) begin
            state_d = SEND;
            shreg_d = SHREG_W'(Data_Input);
          end
        end
        SEND: begin
          if (Chunk_Ready) begin
            shreg_d = shreg_q >> Chunk_Width;
            if (terminal) begin
              state_d = DONE;
            end
          end
        end
        DONE:    state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      shreg_q <= '0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
    end
  end

  assign Chunk_Valid  = (state_q == SEND);
  assign Chunk_Output = (state_q == SEND) ? shreg_q[Chunk_Width-1:0] : '0;
  assign Last_Chunk   = (state_q == SEND) && terminal;
  assign Busy         = (state_q != IDLE);
  assign Done         = (state_q == DONE);

endmodule
